// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Decode-stage pipeline hazard controller. Detects load-use hazards that the
// forwarding path cannot cover, flushes the front end on a taken branch, and
// freezes the pipeline while a multi-cycle memory instruction (CALL/RET/INT
// 32-bit PC transfer) occupies MEM.
//
// Parameters
//   MEM_HOLD_CYCLES  extra cycles a flagged instruction stays in MEM (1..15)
//
// Optional feature
//   HAZARD_PERF_CNT_EN  when defined, builds saturating 16-bit counters for
//                       stall cycles and front-end flushes. When undefined,
//                       stall_cycles and flush_count are tied to 0.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   id_src_addr/used    source operand of the instruction in ID
//   id_dst_addr/used    destination register of the ID instruction read as operand
//   ex_dst_addr         destination register of the instruction in EX
//   ex_mem_read         EX instruction is a load or POP
//   ex_branch_taken     branch resolved taken in EX
//   mem_two_cycle       MEM instruction needs extra memory cycles
//   pc_write, if_id_write, id_ex_write, ex_mem_write   register write enables
//   if_id_flush         clear IF/ID
//   id_ex_bubble        load a NOP into ID/EX
//   mem_wb_bubble       load a NOP into MEM/WB
//   mem_second          MEM is in an extra memory cycle
//   state               FSM state (00 RUN, 01 MEM_HOLD)
//   stall_cycles        perf counter: non-reset cycles with pc_write == 0
//   flush_count         perf counter: non-reset cycles with if_id_flush == 1
//
// Handshake note: there is no valid/ready handshake here; every control output
// is a combinational (Mealy) function of state_q, cnt_q and the current inputs,
// so the pipeline sees the decision in the same cycle the hazard appears.
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned MEM_HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_src_addr,
  input  logic [2:0]  id_dst_addr,
  input  logic        id_src_used,
  input  logic        id_dst_used,
  input  logic [2:0]  ex_dst_addr,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_two_cycle,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        mem_wb_bubble,
  output logic        mem_second,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_HOLD = 2'b01
  } state_e;

  // Value loaded into the hold counter on entry to MEM_HOLD. The entry cycle
  // itself is the first frozen cycle, hence the minus one.
  localparam logic [3:0] HOLD_LOAD = 4'(MEM_HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;

  logic load_use;
  logic front_rules; // branch / load-use rules may be evaluated this cycle

  // Full 3-bit compare; register 0 is an ordinary register here.
  assign load_use = ex_mem_read &&
                    ((id_src_used && (id_src_addr == ex_dst_addr)) ||
                     (id_dst_used && (id_dst_addr == ex_dst_addr)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_second    = 1'b0;
    front_rules   = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;

    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
      state_d       = ST_RUN;
      cnt_d         = 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_two_cycle) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            cnt_d         = HOLD_LOAD;
            state_d       = ST_MEM_HOLD;
          end else begin
            front_rules = 1'b1;
          end
        end
        ST_MEM_HOLD: begin
          // mem_two_cycle is ignored while the flagged instruction is held.
          mem_second = 1'b1;
          if (cnt_q != 4'd0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            cnt_d         = cnt_q - 4'd1;
          end else begin
            // Final cycle: pipeline advances, so a branch or load-use that
            // waited behind the freeze is handled now.
            front_rules = 1'b1;
            state_d     = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase

      if (front_rules) begin
        if (ex_branch_taken) begin
          // pc_write stays 1 so the PC loads the branch target.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    if (if_id_flush && (flush_q != 16'hFFFF)) flush_d = flush_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 16'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed bench for hazard_unit with MEM_HOLD_CYCLES = 2. Inputs change 1 ns
// after each rising edge; outputs are checked 2 ns later, well before the next
// edge. Expected values are written by hand at each step.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  id_src_addr;
  logic [2:0]  id_dst_addr;
  logic        id_src_used;
  logic        id_dst_used;
  logic [2:0]  ex_dst_addr;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_two_cycle;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        mem_wb_bubble;
  logic        mem_second;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  int tests_run  = 0;
  int tests_fail = 0;

  hazard_unit #(.MEM_HOLD_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_src_addr     (id_src_addr),
    .id_dst_addr     (id_dst_addr),
    .id_src_used     (id_src_used),
    .id_dst_used     (id_dst_used),
    .ex_dst_addr     (ex_dst_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_two_cycle   (mem_two_cycle),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_second      (mem_second),
    .state           (state),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic mtc, input logic br,
                       input logic mr, input logic [2:0] exd,
                       input logic su, input logic [2:0] sa,
                       input logic du, input logic [2:0] da);
    rst             = r;
    mem_two_cycle   = mtc;
    ex_branch_taken = br;
    ex_mem_read     = mr;
    ex_dst_addr     = exd;
    id_src_used     = su;
    id_src_addr     = sa;
    id_dst_used     = du;
    id_dst_addr     = da;
    #2;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  // Checking
  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected vector order: pc, if_id_w, id_ex_w, ex_mem_w, flush, bubble,
  // mem_wb_bubble, mem_second, state
  task automatic check_outs(input string tag, input logic [9:0] exp);
    check({tag, ".pc_write"},      {15'd0, pc_write},      {15'd0, exp[9]});
    check({tag, ".if_id_write"},   {15'd0, if_id_write},   {15'd0, exp[8]});
    check({tag, ".id_ex_write"},   {15'd0, id_ex_write},   {15'd0, exp[7]});
    check({tag, ".ex_mem_write"},  {15'd0, ex_mem_write},  {15'd0, exp[6]});
    check({tag, ".if_id_flush"},   {15'd0, if_id_flush},   {15'd0, exp[5]});
    check({tag, ".id_ex_bubble"},  {15'd0, id_ex_bubble},  {15'd0, exp[4]});
    check({tag, ".mem_wb_bubble"}, {15'd0, mem_wb_bubble}, {15'd0, exp[3]});
    check({tag, ".mem_second"},    {15'd0, mem_second},    {15'd0, exp[2]});
    check({tag, ".state"},         {14'd0, state},         {14'd0, exp[1:0]});
  endtask

  // Hand-written output patterns (state in low two bits)
  localparam logic [9:0] DEF_RUN   = 10'b1111_000_0_00;
  localparam logic [9:0] RST_OUT   = 10'b0000_111_0_00;
  localparam logic [9:0] LOADUSE   = 10'b0011_010_0_00;
  localparam logic [9:0] BRANCH    = 10'b1111_110_0_00;
  localparam logic [9:0] FRZ_RUN   = 10'b0000_001_0_00;
  localparam logic [9:0] FRZ_HOLD  = 10'b0000_001_1_01;
  localparam logic [9:0] FIN_HOLD  = 10'b1111_000_1_01;
  localparam logic [9:0] FIN_BR    = 10'b1111_110_1_01;

  logic [15:0] exp_stall;
  logic [15:0] exp_flush;

  initial begin
`ifdef HAZARD_PERF_CNT_EN
    exp_stall = 16'd3;
    exp_flush = 16'd2;
`else
    exp_stall = 16'd0;
    exp_flush = 16'd0;
`endif

    // Reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_outs("reset", RST_OUT);
    check("reset.stall_cycles", stall_cycles, 16'd0);
    check("reset.flush_count",  flush_count,  16'd0);

    next_cycle(); idle_inputs();
    check_outs("after_reset", DEF_RUN);

    // Perf: 3 load-use stalls, 2 taken branches
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0);
      check_outs("perf_loaduse", LOADUSE);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
      check_outs("perf_branch", BRANCH);
    end
    next_cycle(); idle_inputs();
    check("perf.stall_cycles", stall_cycles, exp_stall);
    check("perf.flush_count",  flush_count,  exp_flush);

    // Load-use on src, then defaults when ex_mem_read drops
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0);
    check_outs("loaduse_src", LOADUSE);
    next_cycle(); idle_inputs();
    check_outs("loaduse_src_next", DEF_RUN);

    // Load-use on dst operand
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 3'd1, 1'b1, 3'd5);
    check_outs("loaduse_dst", LOADUSE);

    // Same addresses, neither operand used
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 3'd3);
    check_outs("no_use", DEF_RUN);

    // Address differs in one bit
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 3'd7);
    check_outs("addr_mismatch", DEF_RUN);

    // Register 0 is not special
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4);
    check_outs("reg0_loaduse", LOADUSE);

    // Match but EX is not a load
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 3'd6, 1'b1, 3'd6);
    check_outs("no_load", DEF_RUN);

    // Branch beats load-use
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0);
    check_outs("branch_over_loaduse", BRANCH);

    // Multi-cycle MEM, mem_two_cycle held high through the hold
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_outs("mem2_c0", FRZ_RUN);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_outs("mem2_c1", FRZ_HOLD);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_outs("mem2_c2", FIN_HOLD);
    next_cycle(); idle_inputs();
    check_outs("mem2_c3", DEF_RUN);

    // Mem freeze beats branch; branch acted on in the final hold cycle
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0, 3'd0);
    check_outs("memhold_br_c0", FRZ_RUN);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_outs("memhold_br_c1", FRZ_HOLD);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_outs("memhold_br_c2", FIN_BR);
    next_cycle(); idle_inputs();
    check_outs("memhold_br_c3", DEF_RUN);

    // Reset in the middle of MEM_HOLD
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_outs("rst_hold_c0", FRZ_RUN);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_outs("rst_hold_c1", {RST_OUT[9:2], 2'b01});
    next_cycle(); idle_inputs();
    check_outs("rst_hold_after", DEF_RUN);
    check("rst_hold.stall_cycles", stall_cycles, 16'd0);
    check("rst_hold.flush_count",  flush_count,  16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    tests_run++;
    tests_fail++;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
